// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
//   REG_ADDR_W : register address width
//   REG_DATA_W : register data width
//   NUM_REGS   : number of architectural registers
//   rr_side_e  : round-robin pointer encoding for the two writeback sources
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 8;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock and asynchronous active-high reset
//   req[1:0] : request vector, bit 0 = side A, bit 1 = side B
//   gnt[1:0] : combinational one-hot (or zero) grant
// The pointer only moves after a contested cycle, so a lone requester never
// disturbs the fairness order between the two sides.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_side_e ptr_q;
    rr_side_e ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt   = (ptr_q == RR_A) ? 2'b01 : 2'b10;
                ptr_d = (ptr_q == RR_A) ? RR_B : RR_A;
            end
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= RR_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file writeback scheduler with a busy-bit scoreboard.
//   clk, rst                          : clock, asynchronous active-high reset
//   iss_valid/iss_dest/iss_src1/2     : instruction presented by issue stage
//   iss_ready                         : no hazard on any operand or destination
//   a_valid/a_dest/a_data, a_ready    : ALU writeback request and grant
//   b_valid/b_dest/b_data, b_ready    : memory writeback request and grant
//   reg_write_en/dest/data            : registered register-file write port
//   busy                              : bit n set while register n awaits writeback
//   err_wb_unbusy                     : sticky, a writeback targeted a non-busy register
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_dest,
    input  logic [ADDR_W-1:0]       iss_src1,
    input  logic [ADDR_W-1:0]       iss_src2,
    output logic                    iss_ready,
    input  logic                    a_valid,
    input  logic [ADDR_W-1:0]       a_dest,
    input  logic [DATA_W-1:0]       a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [ADDR_W-1:0]       b_dest,
    input  logic [DATA_W-1:0]       b_data,
    output logic                    b_ready,
    output logic                    reg_write_en,
    output logic [ADDR_W-1:0]       reg_write_dest,
    output logic [DATA_W-1:0]       reg_write_data,
    output logic [(1<<ADDR_W)-1:0]  busy,
    output logic                    err_wb_unbusy
);

    localparam int NR = 1 << ADDR_W;

    logic [NR-1:0]     busy_q, busy_d;
    logic [NR-1:0]     set_vec, clr_vec;
    logic              we_q;
    logic [ADDR_W-1:0] wdest_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q, err_d;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] g_dest;
    logic [DATA_W-1:0] g_data;
    logic              g_unbusy;

    // Requests are masked during reset so no grant is visible while rst is high.
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid & ~rst, a_valid & ~rst}),
        .gnt (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign any_gnt = |gnt;
    assign g_dest  = gnt[1] ? b_dest : a_dest;
    assign g_data  = gnt[1] ? b_data : a_data;

    // No bypass: a register cleared this cycle only becomes usable next cycle.
    assign iss_ready = ~busy_q[iss_src1] & ~busy_q[iss_src2] & ~busy_q[iss_dest];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && iss_ready) set_vec[iss_dest] = 1'b1;
        if (we_q) clr_vec[wdest_q] = 1'b1;
        // Set is applied after clear so a same-bit collision leaves it busy.
        busy_d   = (busy_q & ~clr_vec) | set_vec;
        // A register being retired this cycle counts as no longer busy.
        g_unbusy = ~busy_q[g_dest] | clr_vec[g_dest];
        err_d    = err_q | (any_gnt & g_unbusy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            we_q    <= 1'b0;
            wdest_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            we_q   <= any_gnt;
            if (any_gnt) begin
                wdest_q <= g_dest;
                wdata_q <= g_data;
            end
        end
    end

    assign reg_write_en   = we_q;
    assign reg_write_dest = wdest_q;
    assign reg_write_data = wdata_q;
    assign busy           = busy_q;
    assign err_wb_unbusy  = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [2:0]  iss_dest, iss_src1, iss_src2;
    logic        iss_ready;
    logic        a_valid, b_valid;
    logic [2:0]  a_dest, b_dest;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  busy;
    logic        err_wb_unbusy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] m_busy;
    logic       m_ptr;
    logic       m_err;

    regfile_wb_sched dut (
        .clk            (clk),
        .rst            (rst),
        .iss_valid      (iss_valid),
        .iss_dest       (iss_dest),
        .iss_src1       (iss_src1),
        .iss_src2       (iss_src2),
        .iss_ready      (iss_ready),
        .a_valid        (a_valid),
        .a_dest         (a_dest),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_dest         (b_dest),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .busy           (busy),
        .err_wb_unbusy  (err_wb_unbusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 8'h00;
        m_ptr  = 1'b0;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: check outputs at the falling edge against the model,
    // advance the model for the coming rising edge, then step past that edge.
    task automatic step(input string tag);
        logic  exp_ir, ga, gb, wrote;
        logic  [2:0] gd;
        logic  [7:0] nb;
        wr_t   e;
        @(negedge clk);
        exp_ir = !(m_busy[iss_src1] || m_busy[iss_src2] || m_busy[iss_dest]);
        ga = a_valid && (!b_valid || (m_ptr == 1'b0));
        gb = b_valid && (!a_valid || (m_ptr == 1'b1));
        chk({tag, ".iss_ready"}, iss_ready, exp_ir);
        chk({tag, ".a_ready"}, a_ready, ga);
        chk({tag, ".b_ready"}, b_ready, gb);
        chk({tag, ".busy"}, busy, m_busy);
        chk({tag, ".err"}, err_wb_unbusy, m_err);
        wrote = 1'b0;
        e.dest = 3'd0;
        e.data = 16'h0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wrote = 1'b1;
            chk({tag, ".we"}, reg_write_en, 1'b1);
            chk({tag, ".wdest"}, reg_write_dest, e.dest);
            chk({tag, ".wdata"}, reg_write_data, e.data);
        end else begin
            chk({tag, ".we"}, reg_write_en, 1'b0);
        end
        nb = m_busy;
        if (wrote) nb[e.dest] = 1'b0;
        if (iss_valid && exp_ir) nb[iss_dest] = 1'b1;
        if (ga || gb) begin
            gd = ga ? a_dest : b_dest;
            if (!m_busy[gd] || (wrote && e.dest == gd)) m_err = 1'b1;
            exp_q.push_back('{dest: gd, data: (ga ? a_data : b_data)});
        end
        if (a_valid && b_valid) m_ptr = ~m_ptr;
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        iss_valid = 1'b1;
        iss_dest  = d;
        iss_src1  = s1;
        iss_src2  = s2;
    endtask

    initial begin
        rst = 1'b1;
        iss_valid = 1'b0; iss_dest = 3'd0; iss_src1 = 3'd0; iss_src2 = 3'd0;
        a_valid = 1'b1; a_dest = 3'd1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_dest = 3'd2; b_data = 16'hBBBB;
        model_reset();

        // Reset state, with both requesters asserted during reset
        #3;
        chk("rst.busy", busy, 8'h00);
        chk("rst.we", reg_write_en, 1'b0);
        chk("rst.wdest", reg_write_dest, 3'd0);
        chk("rst.wdata", reg_write_data, 16'h0);
        chk("rst.err", err_wb_unbusy, 1'b0);
        chk("rst.a_ready", a_ready, 1'b0);
        chk("rst.b_ready", b_ready, 1'b0);
        chk("rst.iss_ready", iss_ready, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle");

        // RAW hazard on r3, resolved by an ALU writeback
        issue(3'd3, 3'd1, 3'd2);
        step("iss3");
        issue(3'd6, 3'd3, 3'd0);
        step("raw_blk0");
        a_valid = 1'b1; a_dest = 3'd3; a_data = 16'h1234;
        step("alu_gnt");
        a_valid = 1'b0;
        step("alu_wr");
        step("raw_acc");
        iss_valid = 1'b0;

        // Mark r0,r1,r2,r4 busy for the contested sequence
        issue(3'd0, 3'd7, 3'd7); step("iss0");
        issue(3'd1, 3'd7, 3'd7); step("iss1");
        issue(3'd2, 3'd7, 3'd7); step("iss2");
        issue(3'd4, 3'd7, 3'd7); step("iss4");
        iss_valid = 1'b0;

        // Four contested cycles: expect A,B,A,B and four back-to-back writes
        a_valid = 1'b1; a_dest = 3'd0; a_data = 16'hA000;
        b_valid = 1'b1; b_dest = 3'd1; b_data = 16'hB001;
        step("rr0");
        a_dest = 3'd2; a_data = 16'hA002;
        step("rr1");
        b_dest = 3'd4; b_data = 16'hB004;
        step("rr2");
        a_dest = 3'd6; a_data = 16'hA006;
        step("rr3");
        a_valid = 1'b0; b_valid = 1'b0;

        // WAW on r4: blocked until its pending write retires
        issue(3'd4, 3'd7, 3'd7);
        step("waw_blk");
        step("waw_acc");
        iss_valid = 1'b0;
        step("rr_tail");

        // Writeback to a non-busy register sets the sticky error
        b_valid = 1'b1; b_dest = 3'd5; b_data = 16'h5555;
        step("unbusy_gnt");
        b_valid = 1'b0;
        step("unbusy_wr");
        step("err_sticky0");
        step("err_sticky1");

        // Reset between a grant and its write
        issue(3'd7, 3'd0, 3'd0);
        step("iss7");
        iss_valid = 1'b0;
        a_valid = 1'b1; a_dest = 3'd7; a_data = 16'h7777;
        @(negedge clk);
        chk("mid.a_ready", a_ready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.we", reg_write_en, 1'b0);
        chk("mid.busy", busy, 8'h00);
        chk("mid.err", err_wb_unbusy, 1'b0);
        chk("mid.a_ready", a_ready, 1'b0);
        chk("mid.iss_ready", iss_ready, 1'b1);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.we_edge", reg_write_en, 1'b0);
        rst = 1'b0;
        model_reset();
        step("post_rst");
        step("post_rst2");

        // Pointer back at A after reset
        a_valid = 1'b1; a_dest = 3'd1; a_data = 16'h0A01;
        b_valid = 1'b1; b_dest = 3'd2; b_data = 16'h0B02;
        step("ptrA");
        a_valid = 1'b0;
        step("ptrA_b");
        b_valid = 1'b0;
        step("ptrA_wr");
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, register data width; ADDR_W, 3, register address width (NUM_REGS = 2**ADDR_W = 8).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 iss_valid  in  1  issue stage presents an instruction.
REQ-006 iss_dest  in  ADDR_W  destination register of the instruction.
REQ-007 iss_src1, iss_src2  in  ADDR_W each  source registers.
REQ-008 iss_ready  out  1  instruction accepted this cycle when high with iss_valid.
REQ-009 a_valid, a_dest, a_data  in  1/ADDR_W/DATA_W  ALU writeback request.
REQ-010 a_ready  out  1  ALU request granted this cycle.
REQ-011 b_valid, b_dest, b_data  in  1/ADDR_W/DATA_W  memory writeback request.
REQ-012 b_ready  out  1  memory request granted this cycle.
REQ-013 reg_write_en, reg_write_dest, reg_write_data  out  1/ADDR_W/DATA_W  register-file write port drive.
REQ-014 busy  out  NUM_REGS  scoreboard, bit n = register n has a pending write.
REQ-015 err_wb_unbusy  out  1  sticky: writeback granted to a non-busy register.

Function
REQ-016 iss_ready SHALL equal !busy[iss_src1] && !busy[iss_src2] && !busy[iss_dest], from the registered busy vector only (no bypass), independent of iss_valid.
REQ-017 Issue accept (iss_valid && iss_ready) SHALL set busy[iss_dest] at the next rising edge.
REQ-018 Grant SHALL be combinational: only one valid -> grant it; both valid -> grant the side holding the round-robin pointer; neither -> no grant.
REQ-019 Round-robin pointer SHALL toggle to the other side after any cycle where both were valid; unchanged otherwise; reset value points to A.
REQ-020 a_ready/b_ready SHALL be high only for the granted side; at most one high per cycle; a requester holds valid/dest/data stable until granted.
REQ-021 On grant, reg_write_en SHALL be 1 on the next cycle with reg_write_dest/reg_write_data captured from the granted side (latency 1); otherwise reg_write_en = 0 and dest/data hold.
REQ-022 busy[reg_write_dest] SHALL clear at the edge ending a cycle with reg_write_en = 1 (same edge the register file writes), so dependents issue no earlier than the following cycle.
REQ-023 Simultaneous set and clear of one bit SHALL leave it set; unreachable via REQ-016, but defined.
REQ-024 A grant whose dest is not busy (and not being cleared in the same cycle) SHALL set err_wb_unbusy; the write still occurs.
REQ-025 Back-to-back grants every cycle SHALL be supported: throughput 1 write/cycle.

Reset
REQ-026 On rst: busy = 0, reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0, pointer = A, err_wb_unbusy = 0; immediate, clock-independent.
REQ-027 Reset mid-operation SHALL drop any captured-but-unperformed write and all pending busy bits; no write issued after rst deasserts without a new grant.
REQ-028 During reset a_ready, b_ready SHALL be 0 and iss_ready SHALL be 1.

Structure
REQ-029 Shared package regfile_pkg SHALL hold REG_ADDR_W = 3, REG_DATA_W = 16, NUM_REGS = 8; parameter defaults reference it.
REQ-030 Two-way round-robin arbiter SHALL be a sub-module rr_arb2 (req[1:0], gnt[1:0], pointer register inside).
REQ-031 Scoreboard and write-port register SHALL live in regfile_wb_sched.

Verification
REQ-032 Reset, then issue dest=3 src=1,2 -> busy=0x08 next cycle; issue src1=3 -> iss_ready=0 until after reg_write_en for dest 3.
REQ-033 a_valid dest=3 data=0x1234 alone -> a_ready=1 same cycle; next cycle reg_write_en=1 dest=3 data=0x1234; busy[3]=0 the cycle after.
REQ-034 a and b valid for 4 consecutive cycles (distinct busy dests) -> grants A,B,A,B; reg_write_en high 4 consecutive cycles.
REQ-035 b_valid dest=5 with busy[5]=0 -> write performed, err_wb_unbusy=1 and stays 1 until rst.
REQ-036 Grant in cycle N, rst asserted asynchronously before edge N+1 -> reg_write_en never asserts, busy=0, pointer=A.
REQ-037 Issue dest=4 with busy[4]=1 (WAW) -> iss_ready=0; accepted the cycle after busy[4] clears.
